// File: rtl/riscv_pkg.sv
// Shared core constants and fetch control state encoding.
// Imported by the fetch stage and its skid buffer.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        FS_RUN,
        FS_HOLD,
        FS_FLUSH
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry pc+instr holding register for the fetch stage.
// Flush beats load, load beats release.
module fetch_skid_buf
    import riscv_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               rel,
    input  logic               flush,
    input  logic [31:0]        pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               valid,
    output logic [31:0]        pc,
    output logic [INSTR_W-1:0] instr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= pc_in;
            instr <= instr_in;
        end else if (rel) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem read port, skid buffer, redirect.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky misaligned-target fault.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [31:0]        id_pc,
    output logic [INSTR_W-1:0] id_instr
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic               fetch_fault
`endif
);

    logic [31:0]        pc_q;
    logic               req_valid_q;
    logic [31:0]        req_pc_q;
    logic               skid_valid;
    logic [31:0]        skid_pc;
    logic [INSTR_W-1:0] skid_instr;
    fetch_state_e       st_q;
    fetch_state_e       st_d;
    logic               blocked;
    logic [31:0]        tgt_pc;
    logic               issue;
    logic               capture;
    logic               rel;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            fault_q <= 1'b1;
        end
    end

    assign blocked     = fault_q;
    assign tgt_pc      = redirect_pc;
    assign fetch_fault = fault_q;
`else
    assign blocked = 1'b0;
    assign tgt_pc  = redirect_pc & ~32'h3;
`endif

    // HOLD tracks a full skid buffer, so it gates issue.
    assign issue = (st_q != FS_HOLD)
                 & ~(req_valid_q & ~id_ready)
                 & ~redirect_valid
                 & ~blocked;

    assign capture = req_valid_q & ~skid_valid
                   & ~id_ready & ~redirect_valid;
    assign rel     = skid_valid & id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            req_pc_q    <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q        <= tgt_pc;
            req_valid_q <= 1'b0;
        end else if (issue) begin
            req_valid_q <= 1'b1;
            req_pc_q    <= pc_q;
            pc_q        <= pc_q + PC_STEP;
        end else begin
            req_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= FS_RUN;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            FS_RUN:  if (capture) st_d = FS_HOLD;
            FS_HOLD: if (rel) st_d = FS_RUN;
            default: st_d = FS_RUN;
        endcase
        if (redirect_valid) st_d = FS_FLUSH;
    end

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (capture),
        .rel      (rel),
        .flush    (redirect_valid),
        .pc_in    (req_pc_q),
        .instr_in (imem_rdata),
        .valid    (skid_valid),
        .pc       (skid_pc),
        .instr    (skid_instr)
    );

    assign imem_addr = pc_q;
    assign id_valid  = skid_valid | req_valid_q;
    assign id_pc     = skid_valid ? skid_pc : req_pc_q;
    assign id_instr  = skid_valid ? skid_instr : imem_rdata;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the RISC-V core. Holds the program counter, drives the read port of `instr_ram`, and presents fetched instructions with their PC to decode over a valid/ready handshake. Redirects from execute (branch/jump) flush the in-flight fetch. A one-entry skid buffer absorbs the read word when decode stalls.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `imem_addr` output 32: byte address to `instr_ram` `address`.
- `imem_rdata` input 32: `instr_ram` `rdata`; synchronous read, valid the cycle after the address.
- `redirect_valid` input 1: execute requests a PC change.
- `redirect_pc` input 32: target byte address.
- `id_valid` output 1: instruction available to decode.
- `id_ready` input 1: decode accepts this cycle.
- `id_pc` output 32: PC of the presented instruction.
- `id_instr` output 32: presented instruction word.
- `fetch_fault` output 1: misaligned-target fault. Present only with `FETCH_MISALIGN_CHECK_EN`.

## Operation
- Registers: `pc_q`, `req_valid_q`, `req_pc_q`, and the skid buffer (`skid_valid_q`, `skid_pc_q`, `skid_instr_q`).
- `imem_addr = pc_q` at all times. `instr_ram` write enable is owned by the loader, not by this block.
- `issue = ~skid_valid_q & ~(req_valid_q & ~id_ready) & ~redirect_valid`.
  - On issue: `req_valid_q<=1`, `req_pc_q<=pc_q`, `pc_q<=pc_q+4`. The addition wraps modulo 2^32.
  - Otherwise `req_valid_q<=0` and `pc_q` holds.
- Output mux:
  - If `skid_valid_q`: present `skid_pc_q`/`skid_instr_q`.
  - Else: present `req_pc_q`/`imem_rdata`.
  - `id_valid = skid_valid_q | req_valid_q`.
- Stall capture: when `req_valid_q & ~skid_valid_q & ~id_ready & ~redirect_valid`, load the skid buffer from `req_pc_q`/`imem_rdata`.
- Skid release: when `skid_valid_q & id_ready`, clear the skid buffer. Issue resumes the following cycle, which costs one bubble.
- Redirect has the highest priority:
  - `pc_q<=redirect_pc`, `req_valid_q<=0`, `skid_valid_q<=0`.
  - `id_valid` is still driven combinationally that cycle. Decode must ignore it because it generates the redirect.
- Control states, derived from the registers:
  - RUN: no skid, streaming.
  - HOLD: skid valid, waiting on `id_ready`.
  - FLUSH: the one cycle after a redirect, with no request in flight.
  - Transitions: RUN→HOLD on stall capture; HOLD→RUN on release; any→FLUSH on redirect; FLUSH→RUN unconditionally.

## Timing
- Reset values: `pc_q=RESET_PC`, `req_valid_q=0`, `skid_valid_q=0`, hence `id_valid=0` and `imem_addr=RESET_PC`. `id_pc`/`id_instr` are don't-care while `id_valid=0`. `fetch_fault=0`.
- First fetch: the cycle after `rst_n` rises is cycle 0, and it issues `RESET_PC`. `id_valid=1` in cycle 1 with `id_pc=RESET_PC`.
- Throughput: one instruction per cycle while `id_ready=1`.
- Redirect latency: redirect in cycle N → target address presented in N+1 → `id_valid` with the target in N+2.
- A redirect in the same cycle as a stall capture or skid release: the redirect wins and both are dropped.
- Reset asserted mid-stream: all state clears immediately and asynchronously. The in-flight read is discarded.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect whose `redirect_pc[1:0]!=0` sets a sticky `fault_q`. `pc_q` is still loaded, but issue is blocked while `fault_q=1`.
  - `fetch_fault=fault_q`. It is cleared only by reset.
- Not defined: the `fetch_fault` port and its logic are absent. `redirect_pc[1:0]` is forced to 0 when loading `pc_q`.

## Structure
- The shared package `riscv_pkg` holds `RESET_PC_DEFAULT`, `INSTR_W=32`, and `PC_STEP=4`.
- Sub-module `fetch_skid_buf`: the one-entry pc+instr holding register with load, release and flush. It is instantiated once.

## Test plan
- Reset release with `RESET_PC=0`, `id_ready=1`, RAM preloaded with 0x00000013, 0x00100093, … → `id_valid` from cycle 1; `id_pc` 0, 4, 8 on consecutive cycles with the matching words.
- Drop `id_ready` for 3 cycles while `id_pc=8` → `id_pc=8` held stable for 3 cycles; `imem_addr` frozen; after release the next is `id_pc=12` after one bubble, with nothing lost or duplicated.
- Redirect to 0x40 at cycle N → `imem_addr=0x40` at N+1; `id_valid=1`, `id_pc=0x40` at N+2; no instruction from the old path appears after N.
- Redirect to 0x80 in the same cycle as a stall capture → skid empty afterward; next presented `id_pc=0x80`.
- PC wrap: redirect to 0xFFFFFFFC → `id_pc` sequence 0xFFFFFFFC then 0x00000000.
- With `FETCH_MISALIGN_CHECK_EN`: redirect to 0x42 → `fetch_fault=1` from the next cycle, `id_valid=0` until `rst_n` is asserted.
